sdram_bank_model: RTL and testbench
===================================

# sdram_bank_model

Parametrised, cycle-accurate behavioural SDRAM model for simulating memory controllers: configurable width, bank count, rows and columns, tRCD, tRP, tRFC, CAS latency and burst length. Each bank tracks its own open row and timing state. Bursts wrap on burst-aligned column boundaries. Illegal command sequences are reported instead of silently corrupting data. It takes the place of the single-bank, fixed-timing memory model in controller testbenches.

## Interface
- `width`, 8, data bits per beat
- `banks`, 4, bank count (power of 2)
- `rows`, 16, rows per bank (power of 2)
- `cols`, 16, columns per row (power of 2, ≥ burst_len)
- `trcd`, 2, ACT-to-READ/WRITE cycles (≥1)
- `trp`, 2, PRE-to-idle cycles (≥1)
- `trfc`, 4, REFRESH busy cycles (≥1)
- `cas_lat`, 2, READ-to-first-beat cycles (1..4)
- `burst_len`, 4, beats per burst (1, 2, 4 or 8)
- Derived widths: `bank_w`=$clog2(banks), `addr_w`=max($clog2(rows),$clog2(cols))
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cmd`  in  3  0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 PREALL, 6 REFRESH, 7 reserved
- `bank`  in  bank_w  target bank
- `addr`  in  addr_w  row (ACT) or start column (READ/WRITE), LSBs used
- `data_in`  in  width  write beats
- `data_out`  out  width  read beats, 0 when not valid
- `data_valid`  out  1  read beat present
- `cmd_ready`  out  1  non-NOP command accepted this cycle
- `cmd_err`  out  1  one-cycle pulse: previous command rejected

## Operation
- Storage: banks×rows×cols words. Not reset; contents survive `reset`.
- Per-bank FSM: IDLE → (ACT) ACTIVATING, trcd cycles → ACTIVE(row latched) → (PRE/PREALL) PRECHARGING, trp cycles → IDLE.
- Global engine: READY, RD_BURST, WR_BURST, REFRESHING. `cmd_ready`=1 only in READY.
- READ/WRITE legal only to a bank in ACTIVE. Beat k addresses column {start[hi], (start[lo]+k) mod burst_len}, where lo = log2(burst_len) bits.
- WRITE captures `data_in` on the command cycle and the following burst_len−1 cycles.
- REFRESH is legal only with all banks IDLE.
- PREALL moves every ACTIVE bank to PRECHARGING. Banks in any other state are left unchanged. PREALL is never an error.
- Errors: ACT to a non-IDLE bank; READ/WRITE to a non-ACTIVE bank; PRE to an ACTIVATING or PRECHARGING bank; REFRESH with any bank non-IDLE; cmd 7; any non-NOP while `cmd_ready`=0. An erroneous command has no effect, and `cmd_err` pulses in the next cycle.
- PRE to an IDLE bank is a legal no-op.
- Bank timers keep counting while a burst or refresh is in progress.

## Timing
- Cycle 0 is the cycle the command is presented and sampled.
- Reset values: `data_out`=0, `data_valid`=0, `cmd_err`=0, `cmd_ready`=1, all banks IDLE, engine READY. These take effect the cycle after `reset` is high.
- `reset` mid-burst or mid-refresh aborts the operation. Beats already written remain. No further beats are driven.
- ACT: the bank accepts READ/WRITE from cycle trcd.
- PRE: the bank is IDLE from cycle trp.
- READ: `data_valid`=1 in cycles cas_lat .. cas_lat+burst_len−1, with no gaps. `cmd_ready`=0 in cycles 1 .. cas_lat+burst_len−1.
- WRITE: `cmd_ready`=0 in cycles 1 .. burst_len−1. A write is visible to a READ issued from cycle burst_len.
- REFRESH: `cmd_ready`=0 in cycles 1 .. trfc−1.
- `cmd_err` asserts in cycle 1 for exactly one cycle.
- A READ to a bank whose PRE was issued earlier is an error even if the row is unchanged.

## Test plan
- Reset, then ACT b0 row 3 at T, WRITE b0 col 0 at T+2 with `data_in` 0xA0..0xA3, READ b0 col 0 at T+6 → `data_valid` in cycles T+8..T+11 with 0xA0, 0xA1, 0xA2, 0xA3; `cmd_err` stays 0.
- Wrap: from the previous state, READ b0 col 2 → beats 0xA2, 0xA3, 0xA0, 0xA1.
- Timing violations: READ b1 at T+1 after ACT b1 at T → `cmd_err`=1 at T+2, no `data_valid`. ACT b1 while b1 is ACTIVE → `cmd_err`. Non-NOP while `cmd_ready`=0 → `cmd_err`.
- Bank independence: write 0x11 to b0 row 1 and 0x22 to b2 row 5, both rows open. Read each → correct data. PREALL, then 2 cycles later REFRESH → accepted, `cmd_ready` low for 3 cycles.
- REFRESH with b3 ACTIVE → `cmd_err`=1, b3 still ACTIVE, and a subsequent READ succeeds.
- Assert `reset` during read beat 2 → `data_valid`=0 the next cycle, `cmd_ready`=1, all banks IDLE. Previously written data is readable after a new ACT.

Source files
------------

// File: rtl/sdram_bank_model.sv
// Cycle-accurate multi-bank SDRAM model. Each bank tracks its open row and timing.
// A single engine serialises read bursts, write bursts and refresh. Illegal commands are flagged.
module sdram_bank_model #(
    parameter int width     = 8,
    parameter int banks     = 4,
    parameter int rows      = 16,
    parameter int cols      = 16,
    parameter int trcd      = 2,
    parameter int trp       = 2,
    parameter int trfc      = 4,
    parameter int cas_lat   = 2,
    parameter int burst_len = 4,
    parameter int bank_w    = $clog2(banks),
    parameter int addr_w    = ($clog2(rows) > $clog2(cols)) ? $clog2(rows) : $clog2(cols)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cmd,
    input  logic [bank_w-1:0] bank,
    input  logic [addr_w-1:0] addr,
    input  logic [width-1:0]  data_in,
    output logic [width-1:0]  data_out,
    output logic              data_valid,
    output logic              cmd_ready,
    output logic              cmd_err
);

    localparam int row_w   = $clog2(rows);
    localparam int col_w   = $clog2(cols);
    localparam int rd_len  = cas_lat + burst_len;
    localparam int max_a   = (trcd > trp) ? trcd : trp;
    localparam int max_b   = (trfc > rd_len) ? trfc : rd_len;
    localparam int cnt_w   = $clog2(((max_a > max_b) ? max_a : max_b) + 1);
    localparam int depth   = banks * rows * cols;
    localparam logic [col_w-1:0] bl_mask = col_w'(burst_len - 1);

    typedef enum logic [2:0] {
        C_NOP, C_ACT, C_READ, C_WRITE, C_PRE, C_PREALL, C_REFRESH, C_RSVD
    } cmd_e;
    typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_state_e;
    typedef enum logic [1:0] {E_READY, E_RD_BURST, E_WR_BURST, E_REFRESHING} engine_e;

    cmd_e              cmd_s;
    bank_state_e       bst_q  [banks];
    bank_state_e       bst_d  [banks];
    logic [cnt_w-1:0]  btmr_q [banks];
    logic [cnt_w-1:0]  btmr_d [banks];
    logic [row_w-1:0]  brow_q [banks];
    logic [row_w-1:0]  brow_d [banks];
    engine_e           eng_q, eng_d;
    logic [cnt_w-1:0]  cnt_q, cnt_d;
    logic [bank_w-1:0] bb_q, bb_d;
    logic [row_w-1:0]  br_q, br_d;
    logic [col_w-1:0]  bc_q, bc_d;
    logic [width-1:0]  data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              cmd_err_q, cmd_err_d;
    logic              all_idle, err, accept, wr_en;
    logic [cnt_w-1:0]  rd_beat, wr_beat;
    logic [width-1:0]  mem [depth];

    assign cmd_s = cmd_e'(cmd);

    // Beats wrap inside the burst-aligned block that holds the start column.
    function automatic logic [col_w-1:0] beat_col(input logic [col_w-1:0] start,
                                                  input logic [cnt_w-1:0] beat);
        return (start & ~bl_mask) | ((start + col_w'(beat)) & bl_mask);
    endfunction

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < banks; i++) begin
            if (bst_q[i] != B_IDLE) all_idle = 1'b0;
        end
        err = 1'b0;
        if (cmd_s != C_NOP) begin
            if (!cmd_ready_q) begin
                err = 1'b1;
            end else begin
                case (cmd_s)
                    C_ACT:           err = (bst_q[bank] != B_IDLE);
                    C_READ, C_WRITE: err = (bst_q[bank] != B_ACTIVE);
                    C_PRE:           err = (bst_q[bank] inside {B_ACTIVATING, B_PRECHARGING});
                    C_REFRESH:       err = !all_idle;
                    C_RSVD:          err = 1'b1;
                    default:         err = 1'b0;
                endcase
            end
        end
        accept = cmd_ready_q && (cmd_s != C_NOP) && !err;
    end

    always_comb begin
        for (int i = 0; i < banks; i++) begin
            bst_d[i]  = bst_q[i];
            btmr_d[i] = btmr_q[i] + 1'b1;
            brow_d[i] = brow_q[i];
            case (bst_q[i])
                B_ACTIVATING:  if (btmr_q[i] == cnt_w'(trcd - 1)) bst_d[i] = B_ACTIVE;
                B_PRECHARGING: if (btmr_q[i] == cnt_w'(trp - 1)) bst_d[i] = B_IDLE;
                default: ;
            endcase
            if (accept && cmd_s == C_ACT && bank == bank_w'(i)) begin
                bst_d[i]  = (trcd == 1) ? B_ACTIVE : B_ACTIVATING;
                btmr_d[i] = cnt_w'(1);
                brow_d[i] = addr[row_w-1:0];
            end
            if (accept && bst_q[i] == B_ACTIVE &&
                ((cmd_s == C_PRE && bank == bank_w'(i)) || cmd_s == C_PREALL)) begin
                bst_d[i]  = (trp == 1) ? B_IDLE : B_PRECHARGING;
                btmr_d[i] = cnt_w'(1);
            end
        end
    end

    // cnt_d is the number of the upcoming cycle relative to the accepted command.
    always_comb begin
        eng_d   = eng_q;
        cnt_d   = cnt_q + 1'b1;
        bb_d    = bb_q;
        br_d    = br_q;
        bc_d    = bc_q;
        wr_en   = 1'b0;
        wr_beat = cnt_q;
        case (eng_q)
            E_READY: begin
                cnt_d   = cnt_w'(1);
                wr_beat = '0;
                if (accept && (cmd_s == C_READ || cmd_s == C_WRITE)) begin
                    bb_d = bank;
                    br_d = brow_q[bank];
                    bc_d = addr[col_w-1:0];
                end
                if (accept) begin
                    case (cmd_s)
                        C_READ:    eng_d = E_RD_BURST;
                        C_WRITE: begin
                            wr_en = 1'b1;
                            if (burst_len > 1) eng_d = E_WR_BURST;
                        end
                        C_REFRESH: if (trfc > 1) eng_d = E_REFRESHING;
                        default: ;
                    endcase
                end
            end
            E_RD_BURST:   if (cnt_q == cnt_w'(rd_len - 1)) eng_d = E_READY;
            E_WR_BURST: begin
                wr_en = 1'b1;
                if (cnt_q == cnt_w'(burst_len - 1)) eng_d = E_READY;
            end
            E_REFRESHING: if (cnt_q == cnt_w'(trfc - 1)) eng_d = E_READY;
            default: eng_d = E_READY;
        endcase
    end

    always_comb begin
        rd_beat      = cnt_d - cnt_w'(cas_lat);
        data_valid_d = (eng_d == E_RD_BURST) && (cnt_d >= cnt_w'(cas_lat));
        data_out_d   = data_valid_d ? mem[{bb_d, br_d, beat_col(bc_d, rd_beat)}] : '0;
        cmd_ready_d  = (eng_d == E_READY);
        cmd_err_d    = err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eng_q        <= E_READY;
            cnt_q        <= '0;
            bb_q         <= '0;
            br_q         <= '0;
            bc_q         <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            cmd_err_q    <= 1'b0;
            for (int i = 0; i < banks; i++) begin
                bst_q[i]  <= B_IDLE;
                btmr_q[i] <= '0;
                brow_q[i] <= '0;
            end
        end else begin
            eng_q        <= eng_d;
            cnt_q        <= cnt_d;
            bb_q         <= bb_d;
            br_q         <= br_d;
            bc_q         <= bc_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            cmd_ready_q  <= cmd_ready_d;
            cmd_err_q    <= cmd_err_d;
            bst_q        <= bst_d;
            btmr_q       <= btmr_d;
            brow_q       <= brow_d;
        end
    end

    // NOTE: storage has no reset so contents survive it; only the write enable is gated.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[{bb_d, br_d, beat_col(bc_d, wr_beat)}] <= data_in;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign cmd_ready  = cmd_ready_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_sdram_bank_model.sv
// Self-checking bench for sdram_bank_model: directed scenarios plus random traffic
// checked against a timestamp-based reference model.
module tb_sdram_bank_model;

    localparam int width = 8, banks = 4, rows = 16, cols = 16;
    localparam int trcd = 2, trp = 2, trfc = 4, cas_lat = 2, burst_len = 4;
    localparam int bank_w = 2, addr_w = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        cmd = '0;
    logic [bank_w-1:0] bank = '0;
    logic [addr_w-1:0] addr = '0;
    logic [width-1:0]  data_in = '0;
    logic [width-1:0]  data_out;
    logic              data_valid, cmd_ready, cmd_err;

    always #5 clk = ~clk;

    sdram_bank_model #(
        .width(width), .banks(banks), .rows(rows), .cols(cols), .trcd(trcd), .trp(trp),
        .trfc(trfc), .cas_lat(cas_lat), .burst_len(burst_len)
    ) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .bank(bank), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .cmd_ready(cmd_ready), .cmd_err(cmd_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: bank state derived from command timestamps, memory as a sparse map.
    typedef struct { int at; bit known; logic [width-1:0] data; } beat_t;
    logic [width-1:0] m_mem [int];
    bit   b_open [banks];
    int   b_row  [banks];
    int   b_act  [banks];
    int   b_pre  [banks];
    int   eng_free;
    bit   wr_busy;
    int   wr_start, wr_bank, wr_row, wr_col;
    beat_t rdq[$];
    bit   exp_ready, exp_err, exp_valid, exp_known;
    logic [width-1:0] exp_data;

    function automatic int key(input int b, input int r, input int c);
        return (b * rows + r) * cols + c;
    endfunction

    function automatic int beat_col(input int start, input int k);
        return (start / burst_len) * burst_len + (start % burst_len + k) % burst_len;
    endfunction

    function automatic bit is_idle(input int i);
        return !b_open[i] && cyc >= b_pre[i] + trp;
    endfunction
    function automatic bit is_active(input int i);
        return b_open[i] && cyc >= b_act[i] + trcd;
    endfunction
    function automatic bit is_transient(input int i);
        return (b_open[i] && cyc < b_act[i] + trcd) || (!b_open[i] && cyc < b_pre[i] + trp);
    endfunction

    task automatic model_step(input int c, input int b, input int a, input logic [width-1:0] d,
                              input bit rst);
        bit err;
        beat_t bt;
        if (rst) begin
            for (int i = 0; i < banks; i++) begin
                b_open[i] = 1'b0;
                b_pre[i]  = -100;
            end
            eng_free = cyc + 1;
            wr_busy  = 1'b0;
            rdq.delete();
            exp_ready = 1'b1; exp_err = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_known = 1'b1;
            return;
        end
        if (wr_busy && cyc > wr_start && cyc < wr_start + burst_len)
            m_mem[key(wr_bank, wr_row, beat_col(wr_col, cyc - wr_start))] = d;
        err = 1'b0;
        if (c != 0) begin
            if (cyc < eng_free || c == 7) err = 1'b1;
            else case (c)
                1:    err = !is_idle(b);
                2, 3: err = !is_active(b);
                4:    err = is_transient(b);
                6:    for (int i = 0; i < banks; i++) if (!is_idle(i)) err = 1'b1;
                default: ;
            endcase
        end
        if (c != 0 && !err) begin
            case (c)
                1: begin b_open[b] = 1'b1; b_row[b] = a; b_act[b] = cyc; end
                2: begin
                    for (int k = 0; k < burst_len; k++) begin
                        int ky;
                        ky = key(b, b_row[b], beat_col(a, k));
                        bt.at    = cyc + cas_lat + k;
                        bt.known = m_mem.exists(ky);
                        bt.data  = bt.known ? m_mem[ky] : '0;
                        rdq.push_back(bt);
                    end
                    eng_free = cyc + cas_lat + burst_len;
                end
                3: begin
                    wr_busy = 1'b1; wr_start = cyc; wr_bank = b; wr_row = b_row[b]; wr_col = a;
                    m_mem[key(b, b_row[b], a)] = d;
                    eng_free = cyc + burst_len;
                end
                4: if (is_active(b)) begin b_open[b] = 1'b0; b_pre[b] = cyc; end
                5: for (int i = 0; i < banks; i++)
                       if (is_active(i)) begin b_open[i] = 1'b0; b_pre[i] = cyc; end
                6: eng_free = cyc + trfc;
                default: ;
            endcase
        end
        exp_err   = err;
        exp_ready = (cyc + 1 >= eng_free);
        exp_valid = 1'b0; exp_data = '0; exp_known = 1'b1;
        if (rdq.size() > 0 && rdq[0].at == cyc + 1) begin
            bt = rdq.pop_front();
            exp_valid = 1'b1; exp_data = bt.data; exp_known = bt.known;
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then sample just after the edge.
    task automatic step(input int c, input int b, input int a, input logic [width-1:0] d,
                        input bit rst);
        cmd = 3'(c); bank = bank_w'(b); addr = addr_w'(a); data_in = d; reset = rst;
        model_step(c, b, a, d, rst);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step(0, 0, 0, '0, 1'b1);
        checks += 4;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cmd_err); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    endtask

    task automatic test_write_read();
        logic [width-1:0] d, want;
        int c, n;
        bit want_valid, want_ready;
        for (int k = 0; k < 13; k++) begin
            c = 0; d = '0;
            case (k)
                0: c = 1;
                2: begin c = 3; d = 8'hA0; end
                3, 4, 5: d = 8'(8'hA0 + k - 2);
                6: c = 2;
                default: ;
            endcase
            step(c, 0, (k == 0) ? 3 : 0, d, 1'b0);
            n = k + 1;
            want_valid = (n >= 8 && n <= 11);
            want_ready = !((n >= 3 && n <= 5) || (n >= 7 && n <= 11));
            want = 8'(8'hA0 + n - 8);
            checks += 3;
            if (cmd_err !== 1'b0) begin errors++; $display("FAIL wr_rd_err c%0d: got %b want 0", n, cmd_err); end
            if (data_valid !== want_valid) begin errors++; $display("FAIL wr_rd_valid c%0d: got %b want %b", n, data_valid, want_valid); end
            if (cmd_ready !== want_ready) begin errors++; $display("FAIL wr_rd_ready c%0d: got %b want %b", n, cmd_ready, want_ready); end
            if (want_valid) begin
                checks++;
                if (data_out !== want) begin errors++; $display("FAIL wr_rd_data c%0d: got %h want %h", n, data_out, want); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [width-1:0] want;
        int n;
        bit want_valid;
        for (int k = 0; k < 7; k++) begin
            step((k == 0) ? 2 : 0, 0, 2, '0, 1'b0);
            n = k + 1;
            want_valid = (n >= 2 && n <= 5);
            want = 8'(8'hA0 + (n % 4));
            checks++;
            if (data_valid !== want_valid) begin errors++; $display("FAIL wrap_valid c%0d: got %b want %b", n, data_valid, want_valid); end
            if (want_valid) begin
                checks++;
                if (data_out !== want) begin errors++; $display("FAIL wrap_data c%0d: got %h want %h", n, data_out, want); end
            end
        end
    endtask

    task automatic test_timing_errors();
        int c, b, n;
        bit want_err;
        for (int k = 0; k < 13; k++) begin
            c = 0; b = 1;
            case (k)
                0: c = 1;
                1: c = 2;
                6: c = 1;
                7: c = 2;
                8: begin c = 3; b = 0; end
                default: ;
            endcase
            step(c, b, 0, '0, 1'b0);
            n = k + 1;
            want_err = (n == 2 || n == 7 || n == 9);
            checks++;
            if (cmd_err !== want_err) begin errors++; $display("FAIL terr_err c%0d: got %b want %b", n, cmd_err, want_err); end
            if (n <= 8) begin
                checks++;
                if (data_valid !== 1'b0) begin errors++; $display("FAIL terr_valid c%0d: got %b want 0", n, data_valid); end
            end
            if (n == 8) begin
                checks++;
                if (cmd_ready !== 1'b0) begin errors++; $display("FAIL terr_busy c%0d: got %b want 0", n, cmd_ready); end
            end
        end
    endtask

    task automatic test_bank_independence();
        logic [width-1:0] d, want;
        int c, b, a, n;
        bit want_valid;
        for (int k = 0; k < 31; k++) begin
            c = 0; b = 0; a = 0; d = '0;
            case (k)
                0: c = 4;
                2: begin c = 1; a = 1; end
                3: begin c = 1; b = 2; a = 5; end
                4: begin c = 3; a = 4; d = 8'h11; end
                5, 6, 7: d = 8'h11;
                8: begin c = 3; b = 2; a = 4; d = 8'h22; end
                9, 10, 11: d = 8'h22;
                12: begin c = 2; a = 4; end
                18: begin c = 2; b = 2; a = 4; end
                24: c = 5;
                26: c = 6;
                default: ;
            endcase
            step(c, b, a, d, 1'b0);
            n = k + 1;
            want_valid = (n >= 14 && n <= 17) || (n >= 20 && n <= 23);
            want = (n <= 17) ? 8'h11 : 8'h22;
            checks += 2;
            if (cmd_err !== 1'b0) begin errors++; $display("FAIL indep_err c%0d: got %b want 0", n, cmd_err); end
            if (data_valid !== want_valid) begin errors++; $display("FAIL indep_valid c%0d: got %b want %b", n, data_valid, want_valid); end
            if (want_valid) begin
                checks++;
                if (data_out !== want) begin errors++; $display("FAIL indep_data c%0d: got %h want %h", n, data_out, want); end
            end
            if (n >= 27) begin
                checks++;
                if (cmd_ready !== (n == 30 || n == 31)) begin errors++; $display("FAIL refresh_ready c%0d: got %b", n, cmd_ready); end
            end
        end
    endtask

    task automatic test_refresh_err();
        int c, n;
        for (int k = 0; k < 10; k++) begin
            c = (k == 0) ? 1 : (k == 2) ? 6 : (k == 3) ? 2 : 0;
            step(c, 3, (k == 0) ? 2 : 0, '0, 1'b0);
            n = k + 1;
            checks += 2;
            if (cmd_err !== (n == 3)) begin errors++; $display("FAIL referr_err c%0d: got %b want %b", n, cmd_err, n == 3); end
            if (data_valid !== (n >= 5 && n <= 8)) begin errors++; $display("FAIL referr_valid c%0d: got %b", n, data_valid); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int c, b, a, n;
        bit want_valid;
        for (int k = 0; k < 17; k++) begin
            c = 0; b = 0; a = 0;
            case (k)
                0: begin c = 1; a = 1; end
                2: begin c = 2; a = 4; end
                7: begin c = 2; a = 4; end
                8: begin c = 1; b = 3; end
                9: begin c = 1; a = 1; end
                11: begin c = 2; a = 6; end
                default: ;
            endcase
            step(c, b, a, '0, k == 6);
            n = k + 1;
            want_valid = (n >= 4 && n <= 6) || (n >= 13 && n <= 16);
            checks += 2;
            if (data_valid !== want_valid) begin errors++; $display("FAIL rstb_valid c%0d: got %b want %b", n, data_valid, want_valid); end
            if (cmd_err !== (n == 8)) begin errors++; $display("FAIL rstb_err c%0d: got %b want %b", n, cmd_err, n == 8); end
            if (want_valid) begin
                checks++;
                if (data_out !== 8'h11) begin errors++; $display("FAIL rstb_data c%0d: got %h want 11", n, data_out); end
            end
            if (n == 7) begin
                checks++;
                if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstb_ready: got %b want 1", cmd_ready); end
            end
        end
    endtask

    task automatic test_random();
        int c, b, a, r;
        logic [width-1:0] d;
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 99);
            c = (r < 40) ? 0 : (r < 55) ? 1 : (r < 67) ? 2 : (r < 79) ? 3 :
                (r < 87) ? 4 : (r < 91) ? 5 : (r < 97) ? 6 : 7;
            b = $urandom_range(0, banks - 1);
            a = (c == 1) ? $urandom_range(0, 3) : $urandom_range(0, cols - 1);
            d = 8'($urandom);
            step(c, b, a, d, $urandom_range(0, 99) == 0);
            checks += 3;
            if (cmd_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, cmd_ready, exp_ready); end
            if (cmd_err !== exp_err) begin errors++; $display("FAIL rnd_err c%0d: got %b want %b", cyc, cmd_err, exp_err); end
            if (data_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, data_valid, exp_valid); end
            if (exp_known) begin
                checks++;
                if (data_out !== exp_data) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", cyc, data_out, exp_data); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_timing_errors();
        test_bank_independence();
        test_refresh_err();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
